// File: rtl/msi_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msi_cache_pkg
// Description : Shared encodings for the MSI cache controller: line states,
//               coherence bus commands, controller FSM states, and the
//               index/tag width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package msi_cache_pkg;

  typedef enum logic [1:0] {
    LS_I = 2'b00,
    LS_S = 2'b01,
    LS_M = 2'b10
  } line_state_t;

  typedef enum logic [1:0] {
    CMD_READ_MISS  = 2'b00,
    CMD_WRITE_MISS = 2'b01,
    CMD_INVALIDATE = 2'b10,
    CMD_WRITE_BACK = 2'b11
  } bus_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WB       = 3'd1,
    ST_MISS_REQ = 3'd2,
    ST_FILL     = 3'd3,
    ST_INV_REQ  = 3'd4,
    ST_RESP     = 3'd5
  } fsm_state_t;

  function automatic int idx_width(input int num_blocks);
    return $clog2(num_blocks);
  endfunction

  function automatic int tag_width(input int addr_w, input int num_blocks);
    return addr_w - $clog2(num_blocks);
  endfunction

endpackage
`default_nettype wire

// File: rtl/msi_cache_array.sv
`default_nettype none
// ============================================================================
// Module      : msi_cache_array
// Description : Direct-mapped tag/state/data storage. Asynchronous CPU and
//               snoop read ports; one write port whose CPU source overrides
//               a snoop state update aimed at the same line.
// Revision    : 1.0 - initial release
// ============================================================================
module msi_cache_array
  import msi_cache_pkg::*;
#(
  parameter int NUM_BLOCKS = 2,
  parameter int IDX_W      = 1,
  parameter int TAG_W      = 2,
  parameter int DATA_W     = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  i_cpu_idx,
  output logic [TAG_W-1:0]  o_cpu_tag,
  output line_state_t       o_cpu_state,
  output logic [DATA_W-1:0] o_cpu_data,
  input  logic [IDX_W-1:0]  i_snp_idx,
  output logic [TAG_W-1:0]  o_snp_tag,
  output line_state_t       o_snp_state,
  output logic [DATA_W-1:0] o_snp_data,
  input  logic              i_snp_we,
  input  line_state_t       i_snp_wstate,
  input  logic              i_cpu_we,
  input  logic [TAG_W-1:0]  i_cpu_wtag,
  input  line_state_t       i_cpu_wstate,
  input  logic [DATA_W-1:0] i_cpu_wdata
);

  logic [TAG_W-1:0]  r_tag   [NUM_BLOCKS];
  line_state_t       r_state [NUM_BLOCKS];
  logic [DATA_W-1:0] r_data  [NUM_BLOCKS];

  assign o_cpu_tag   = r_tag[i_cpu_idx];
  assign o_cpu_state = r_state[i_cpu_idx];
  assign o_cpu_data  = r_data[i_cpu_idx];
  assign o_snp_tag   = r_tag[i_snp_idx];
  assign o_snp_state = r_state[i_snp_idx];
  assign o_snp_data  = r_data[i_snp_idx];

  // Line update: CPU write already accounts for any snoop on the same line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        r_tag[i]   <= '0;
        r_state[i] <= LS_I;
        r_data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        if (i_cpu_we && (i_cpu_idx == IDX_W'(i))) begin
          r_tag[i]   <= i_cpu_wtag;
          r_state[i] <= i_cpu_wstate;
          r_data[i]  <= i_cpu_wdata;
        end else if (i_snp_we && (i_snp_idx == IDX_W'(i))) begin
          r_state[i] <= i_snp_wstate;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/msi_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : msi_cache_ctrl
// Description : Direct-mapped MSI cache controller with a coherence bus and
//               per-cycle snoop handling. Define MSI_CACHE_STATS_EN to add
//               saturating hit_count / miss_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module msi_cache_ctrl
  import msi_cache_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 4,
  parameter int NUM_BLOCKS = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  output logic              bus_req_valid,
  output logic [1:0]        bus_req_cmd,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_data,
  input  logic              bus_req_ready,
  input  logic              bus_fill_valid,
  input  logic [DATA_W-1:0] bus_fill_data,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_cmd,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_wb_valid,
  output logic [DATA_W-1:0] snoop_wb_data
`ifdef MSI_CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int IDX_W = idx_width(NUM_BLOCKS);
  localparam int TAG_W = tag_width(ADDR_W, NUM_BLOCKS);

  fsm_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              r_snp_wb_valid;
  logic [DATA_W-1:0] r_snp_wb_data;

  logic [ADDR_W-1:0] w_addr;
  logic [IDX_W-1:0]  w_cpu_idx, w_snp_idx;
  logic [TAG_W-1:0]  w_cpu_tag, w_snp_tag, w_arr_tag, w_snp_arr_tag, w_cpu_wtag;
  line_state_t       w_arr_state, w_snp_arr_state, w_snp_wstate, w_cpu_wstate, w_cpu_state_eff;
  logic [DATA_W-1:0] w_arr_data, w_snp_arr_data, w_cpu_wdata, w_rdata_nxt, w_bus_data;
  logic [ADDR_W-1:0] w_bus_addr;
  bus_cmd_t          w_bus_cmd;
  logic              w_snp_hit, w_snp_we, w_snp_wb, w_hit, w_cpu_we, w_rdata_ld, w_accept, w_bus_valid;

  // The active request is the live input while idle, the latched one otherwise.
  assign w_addr    = (r_state == ST_IDLE) ? cpu_req_addr : r_addr;
  assign w_cpu_idx = w_addr[IDX_W-1:0];
  assign w_cpu_tag = w_addr[ADDR_W-1:IDX_W];
  assign w_snp_idx = snoop_addr[IDX_W-1:0];
  assign w_snp_tag = snoop_addr[ADDR_W-1:IDX_W];

  msi_cache_array #(
    .NUM_BLOCKS(NUM_BLOCKS), .IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) u_array (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_cpu_idx    (w_cpu_idx),
    .o_cpu_tag    (w_arr_tag),
    .o_cpu_state  (w_arr_state),
    .o_cpu_data   (w_arr_data),
    .i_snp_idx    (w_snp_idx),
    .o_snp_tag    (w_snp_arr_tag),
    .o_snp_state  (w_snp_arr_state),
    .o_snp_data   (w_snp_arr_data),
    .i_snp_we     (w_snp_we),
    .i_snp_wstate (w_snp_wstate),
    .i_cpu_we     (w_cpu_we),
    .i_cpu_wtag   (w_cpu_wtag),
    .i_cpu_wstate (w_cpu_wstate),
    .i_cpu_wdata  (w_cpu_wdata)
  );

  assign w_snp_hit = snoop_valid && (w_snp_arr_tag == w_snp_tag) && (w_snp_arr_state != LS_I);

  // Snoop response: state downgrade and dirty-data supply.
  always_comb begin
    w_snp_we     = 1'b0;
    w_snp_wb     = 1'b0;
    w_snp_wstate = w_snp_arr_state;
    if (w_snp_hit) begin
      case (bus_cmd_t'(snoop_cmd))
        CMD_READ_MISS: begin
          if (w_snp_arr_state == LS_M) begin
            w_snp_we = 1'b1; w_snp_wb = 1'b1; w_snp_wstate = LS_S;
          end
        end
        CMD_WRITE_MISS: begin
          w_snp_we     = 1'b1;
          w_snp_wb     = (w_snp_arr_state == LS_M);
          w_snp_wstate = LS_I;
        end
        CMD_INVALIDATE: begin
          if (w_snp_arr_state == LS_S) begin
            w_snp_we = 1'b1; w_snp_wstate = LS_I;
          end
        end
        default: ;
      endcase
    end
  end

  // The CPU side sees the line as it stands after this cycle's snoop.
  assign w_cpu_state_eff = (w_snp_we && (w_snp_idx == w_cpu_idx)) ? w_snp_wstate : w_arr_state;
  assign w_hit           = (w_arr_tag == w_cpu_tag) && (w_cpu_state_eff != LS_I);

  // Next-state, bus request and CPU-side line update.
  always_comb begin
    w_state_nxt  = r_state;
    w_bus_valid  = 1'b0;
    w_bus_cmd    = CMD_READ_MISS;
    w_bus_addr   = '0;
    w_bus_data   = '0;
    w_cpu_we     = 1'b0;
    w_cpu_wtag   = w_cpu_tag;
    w_cpu_wstate = LS_M;
    w_cpu_wdata  = r_wdata;
    w_rdata_ld   = 1'b0;
    w_rdata_nxt  = r_rdata;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req_valid) begin
          w_accept = 1'b1;
          if (!cpu_req_write && w_hit) begin
            w_rdata_ld = 1'b1; w_rdata_nxt = w_arr_data; w_state_nxt = ST_RESP;
          end else if (cpu_req_write && w_hit && (w_cpu_state_eff == LS_M)) begin
            w_cpu_we    = 1'b1;
            w_cpu_wdata = cpu_req_wdata;
            w_rdata_ld  = 1'b1;
            w_rdata_nxt = cpu_req_wdata;
            w_state_nxt = ST_RESP;
          end else if (cpu_req_write && w_hit) begin
            w_state_nxt = ST_INV_REQ;
          end else if (w_cpu_state_eff == LS_M) begin
            w_state_nxt = ST_WB;
          end else begin
            w_state_nxt = ST_MISS_REQ;
          end
        end
      end
      ST_WB: begin
        w_bus_valid = 1'b1;
        w_bus_cmd   = CMD_WRITE_BACK;
        w_bus_addr  = {w_arr_tag, w_cpu_idx};
        w_bus_data  = w_arr_data;
        if (w_cpu_state_eff != LS_M) begin
          // A snoop already took the dirty victim; memory got it from there.
          w_state_nxt = ST_MISS_REQ;
        end else if (bus_req_ready) begin
          w_cpu_we     = 1'b1;
          w_cpu_wtag   = w_arr_tag;
          w_cpu_wstate = LS_I;
          w_cpu_wdata  = w_arr_data;
          w_state_nxt  = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        w_bus_valid = 1'b1;
        w_bus_cmd   = r_write ? CMD_WRITE_MISS : CMD_READ_MISS;
        w_bus_addr  = r_addr;
        if (bus_req_ready) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (bus_fill_valid) begin
          w_cpu_we     = 1'b1;
          w_cpu_wstate = r_write ? LS_M : LS_S;
          w_cpu_wdata  = r_write ? r_wdata : bus_fill_data;
          w_rdata_ld   = 1'b1;
          w_rdata_nxt  = w_cpu_wdata;
          w_state_nxt  = ST_RESP;
        end
      end
      ST_INV_REQ: begin
        w_bus_valid = 1'b1;
        w_bus_cmd   = CMD_INVALIDATE;
        w_bus_addr  = r_addr;
        if (!w_hit) begin
          // Our shared copy was invalidated first: fetch ownership instead.
          w_state_nxt = ST_MISS_REQ;
        end else if (bus_req_ready) begin
          w_cpu_we    = 1'b1;
          w_rdata_ld  = 1'b1;
          w_rdata_nxt = r_wdata;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, latched request, response data and snoop write-back pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_write        <= 1'b0;
      r_wdata        <= '0;
      r_rdata        <= '0;
      r_snp_wb_valid <= 1'b0;
      r_snp_wb_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr  <= cpu_req_addr;
        r_write <= cpu_req_write;
        r_wdata <= cpu_req_wdata;
      end
      if (w_rdata_ld) r_rdata <= w_rdata_nxt;
      r_snp_wb_valid <= w_snp_wb;
      r_snp_wb_data  <= w_snp_wb ? w_snp_arr_data : '0;
    end
  end

  assign cpu_req_ready  = (r_state == ST_IDLE);
  assign cpu_resp_valid = (r_state == ST_RESP);
  assign cpu_resp_rdata = r_rdata;
  assign bus_req_valid  = w_bus_valid;
  assign bus_req_cmd    = w_bus_cmd;
  assign bus_req_addr   = w_bus_addr;
  assign bus_req_data   = w_bus_data;
  assign snoop_wb_valid = r_snp_wb_valid;
  assign snoop_wb_data  = r_snp_wb_data;

`ifdef MSI_CACHE_STATS_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;

  // Saturating hit/miss counters, bumped when a request is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_accept) begin
      if (w_hit && (r_hit_cnt != 16'hFFFF)) r_hit_cnt <= r_hit_cnt + 16'd1;
      if (!w_hit && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msi_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_msi_cache_ctrl
// Description : Directed self-checking bench for msi_cache_ctrl
//               (ADDR_W=3, DATA_W=4, NUM_BLOCKS=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msi_cache_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cpu_req_valid, cpu_req_write;
  logic [2:0] cpu_req_addr;
  logic [3:0] cpu_req_wdata;
  logic       cpu_req_ready, cpu_resp_valid;
  logic [3:0] cpu_resp_rdata;
  logic       bus_req_valid;
  logic [1:0] bus_req_cmd;
  logic [2:0] bus_req_addr;
  logic [3:0] bus_req_data;
  logic       bus_req_ready, bus_fill_valid;
  logic [3:0] bus_fill_data;
  logic       snoop_valid;
  logic [1:0] snoop_cmd;
  logic [2:0] snoop_addr;
  logic       snoop_wb_valid;
  logic [3:0] snoop_wb_data;
`ifdef MSI_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  msi_cache_ctrl #(.ADDR_W(3), .DATA_W(4), .NUM_BLOCKS(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_write  (cpu_req_write),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .bus_req_valid  (bus_req_valid),
    .bus_req_cmd    (bus_req_cmd),
    .bus_req_addr   (bus_req_addr),
    .bus_req_data   (bus_req_data),
    .bus_req_ready  (bus_req_ready),
    .bus_fill_valid (bus_fill_valid),
    .bus_fill_data  (bus_fill_data),
    .snoop_valid    (snoop_valid),
    .snoop_cmd      (snoop_cmd),
    .snoop_addr     (snoop_addr),
    .snoop_wb_valid (snoop_wb_valid),
    .snoop_wb_data  (snoop_wb_data)
`ifdef MSI_CACHE_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu(input logic w, input logic [2:0] a, input logic [3:0] d);
    cpu_req_valid = 1'b1; cpu_req_write = w; cpu_req_addr = a; cpu_req_wdata = d;
    step();
    cpu_req_valid = 1'b0;
  endtask

  task automatic snoop(input logic [1:0] c, input logic [2:0] a);
    snoop_valid = 1'b1; snoop_cmd = c; snoop_addr = a;
    step();
    snoop_valid = 1'b0;
  endtask

  task automatic grant();
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
  endtask

  task automatic fill(input logic [3:0] d);
    bus_fill_valid = 1'b1; bus_fill_data = d;
    step();
    bus_fill_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    cpu_req_valid = 0; cpu_req_write = 0; cpu_req_addr = 0; cpu_req_wdata = 0;
    bus_req_ready = 0; bus_fill_valid = 0; bus_fill_data = 0;
    snoop_valid = 0; snoop_cmd = 0; snoop_addr = 0;
    #3;
    chk("rst_ready", cpu_req_ready, 1);
    chk("rst_resp", cpu_resp_valid, 0);
    chk("rst_busv", bus_req_valid, 0);
    chk("rst_wbv", snoop_wb_valid, 0);
    chk("rst_rdata", cpu_resp_rdata, 0);
    step(); reset_n = 1'b1; step();

    // Cold read miss, stall on bus_req_ready, fill A
    cpu(0, 3'b010, 4'h0);
    chk("rm_busv", bus_req_valid, 1);
    chk("rm_cmd", bus_req_cmd, 2'b00);
    chk("rm_addr", bus_req_addr, 3'b010);
    step();
    chk("rm_hold_cmd", bus_req_cmd, 2'b00);
    chk("rm_hold_addr", bus_req_addr, 3'b010);
    grant();
    chk("fill_busv", bus_req_valid, 0);
    chk("fill_ready", cpu_req_ready, 0);
    fill(4'hA);
    chk("rm_resp", cpu_resp_valid, 1);
    chk("rm_rdata", cpu_resp_rdata, 4'hA);
    step();
    chk("idle_resp", cpu_resp_valid, 0);
    chk("idle_ready", cpu_req_ready, 1);
    cpu(0, 3'b010, 4'h0);
    chk("rh_resp", cpu_resp_valid, 1);
    chk("rh_rdata", cpu_resp_rdata, 4'hA);
    chk("rh_busv", bus_req_valid, 0);
    step();

    // Write hit in S -> INVALIDATE, then read back
    cpu(1, 3'b010, 4'h5);
    chk("inv_busv", bus_req_valid, 1);
    chk("inv_cmd", bus_req_cmd, 2'b10);
    chk("inv_addr", bus_req_addr, 3'b010);
    grant();
    chk("inv_resp", cpu_resp_valid, 1);
    step();
    cpu(0, 3'b010, 4'h0);
    chk("rb5_rdata", cpu_resp_rdata, 4'h5);
    chk("rb5_busv", bus_req_valid, 0);
    step();

    // Conflict miss with dirty victim -> WRITE_BACK then READ_MISS
    cpu(0, 3'b100, 4'h0);
    chk("wb_cmd", bus_req_cmd, 2'b11);
    chk("wb_addr", bus_req_addr, 3'b010);
    chk("wb_data", bus_req_data, 4'h5);
    step();
    chk("wb_hold_cmd", bus_req_cmd, 2'b11);
    chk("wb_hold_data", bus_req_data, 4'h5);
    grant();
    chk("wbrm_cmd", bus_req_cmd, 2'b00);
    chk("wbrm_addr", bus_req_addr, 3'b100);
    grant();
    fill(4'h3);
    chk("wbrm_rdata", cpu_resp_rdata, 4'h3);
    step();

    // Line1 to M with 7, snoop READ_MISS then WRITE_MISS
    cpu(1, 3'b011, 4'h7);
    chk("wm_cmd", bus_req_cmd, 2'b01);
    chk("wm_addr", bus_req_addr, 3'b011);
    grant();
    fill(4'hF);
    chk("wm_resp", cpu_resp_valid, 1);
    step();
    snoop(2'b00, 3'b011);
    chk("srm_wbv", snoop_wb_valid, 1);
    chk("srm_wbd", snoop_wb_data, 4'h7);
    step();
    chk("srm_wbv_end", snoop_wb_valid, 0);
    cpu(0, 3'b011, 4'h0);
    chk("s_rh_rdata", cpu_resp_rdata, 4'h7);
    chk("s_rh_busv", bus_req_valid, 0);
    step();
    snoop(2'b01, 3'b011);
    chk("swm_s_wbv", snoop_wb_valid, 0);
    cpu(0, 3'b011, 4'h0);
    chk("swm_miss_busv", bus_req_valid, 1);
    chk("swm_miss_cmd", bus_req_cmd, 2'b00);
    grant();
    fill(4'h9);
    chk("swm_rdata", cpu_resp_rdata, 4'h9);
    step();

    // Write hit in S stalled, snoop INVALIDATE converts to WRITE_MISS
    cpu(1, 3'b011, 4'h6);
    chk("cv_inv_cmd", bus_req_cmd, 2'b10);
    step();
    chk("cv_inv_hold", bus_req_cmd, 2'b10);
    snoop(2'b10, 3'b011);
    chk("cv_busv", bus_req_valid, 1);
    chk("cv_cmd", bus_req_cmd, 2'b01);
    chk("cv_addr", bus_req_addr, 3'b011);
    grant();
    fill(4'hE);
    chk("cv_resp", cpu_resp_valid, 1);
    step();
    cpu(0, 3'b011, 4'h0);
    chk("cv_rdata", cpu_resp_rdata, 4'h6);
    chk("cv_busv_hit", bus_req_valid, 0);
    step();

    // Snoop takes dirty victim during WB -> skip to MISS_REQ
    cpu(1, 3'b000, 4'hC);
    chk("v_wm_cmd", bus_req_cmd, 2'b01);
    grant();
    fill(4'h0);
    step();
    cpu(0, 3'b100, 4'h0);
    chk("v_wb_cmd", bus_req_cmd, 2'b11);
    chk("v_wb_addr", bus_req_addr, 3'b000);
    chk("v_wb_data", bus_req_data, 4'hC);
    snoop(2'b00, 3'b000);
    chk("v_swb_valid", snoop_wb_valid, 1);
    chk("v_swb_data", snoop_wb_data, 4'hC);
    chk("v_rm_cmd", bus_req_cmd, 2'b00);
    chk("v_rm_addr", bus_req_addr, 3'b100);
    grant();
    fill(4'h8);
    chk("v_rdata", cpu_resp_rdata, 4'h8);
    step();

    // Reset during FILL
    cpu(0, 3'b010, 4'h0);
    chk("r_rm_cmd", bus_req_cmd, 2'b00);
    grant();
    bus_fill_valid = 1'b1; bus_fill_data = 4'h2;
    #2;
    reset_n = 1'b0;
    #1;
    chk("r_async_ready", cpu_req_ready, 1);
    chk("r_async_busv", bus_req_valid, 0);
    chk("r_async_resp", cpu_resp_valid, 0);
    step();
    chk("r_noresp", cpu_resp_valid, 0);
    bus_fill_valid = 1'b0;
    reset_n = 1'b1;
    step();
    cpu(0, 3'b011, 4'h0);
    chk("r_cold_cmd", bus_req_cmd, 2'b00);
    chk("r_cold_addr", bus_req_addr, 3'b011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msi_cache_ctrl.md
MSI_CACHE_CTRL -- requirements
Module: msi_cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 3: byte-less word address width.
REQ-002 SHALL have parameter DATA_W, default 4: data word width.
REQ-003 SHALL have parameter NUM_BLOCKS, default 2: direct-mapped lines, power of two, >=2; index = addr[log2(NUM_BLOCKS)-1:0], tag = remaining upper bits.
REQ-004 SHALL have port clock, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports cpu_req_valid/cpu_req_write, inputs, 1 each: CPU request and write (1) / read (0).
REQ-007 SHALL have ports cpu_req_addr (in, ADDR_W), cpu_req_wdata (in, DATA_W), cpu_req_ready (out, 1): request address, write data, accept.
REQ-008 SHALL have ports cpu_resp_valid (out, 1), cpu_resp_rdata (out, DATA_W): one-cycle completion pulse, read data.
REQ-009 SHALL have ports bus_req_valid (out, 1), bus_req_cmd (out, 2), bus_req_addr (out, ADDR_W), bus_req_data (out, DATA_W), bus_req_ready (in, 1): coherence bus request, cmd READ_MISS=00, WRITE_MISS=01, INVALIDATE=10, WRITE_BACK=11.
REQ-010 SHALL have ports bus_fill_valid (in, 1), bus_fill_data (in, DATA_W): memory fill return.
REQ-011 SHALL have ports snoop_valid (in, 1), snoop_cmd (in, 2), snoop_addr (in, ADDR_W): other caches' bus traffic, same encoding.
REQ-012 SHALL have ports snoop_wb_valid (out, 1), snoop_wb_data (out, DATA_W): dirty data supplied on snoop hit in M.

Function
REQ-013 Line states SHALL be I=00, S=01, M=10; hit = tag match and state != I.
REQ-014 FSM states SHALL be IDLE, WB, MISS_REQ, FILL, INV_REQ, RESP; cpu_req_ready = 1 only in IDLE.
REQ-015 Read hit (S/M) or write hit in M SHALL complete with cpu_resp_valid the cycle after acceptance (IDLE->RESP->IDLE); write updates data, state M.
REQ-016 Write hit in S SHALL go INV_REQ, hold INVALIDATE until bus_req_ready, then set M, write data, RESP.
REQ-017 Miss with victim in M SHALL first go WB, issue WRITE_BACK with victim tag|index and data until bus_req_ready, then MISS_REQ.
REQ-018 MISS_REQ SHALL hold READ_MISS (read) or WRITE_MISS (write) until bus_req_ready, then FILL.
REQ-019 FILL SHALL wait for bus_fill_valid; install tag, state S with fill data (read, rdata = fill data) or M with cpu wdata (write); then RESP.
REQ-020 Bus outputs SHALL stay stable while bus_req_valid=1 and bus_req_ready=0.
REQ-021 Snoops SHALL be processed every cycle regardless of FSM state: READ_MISS hit in M -> S with snoop_wb pulse next cycle; WRITE_MISS hit in M -> I with snoop_wb pulse; WRITE_MISS/INVALIDATE hit in S -> I; all other cases no effect.
REQ-022 Snoop and CPU-side update to the same line in one cycle: snoop applied first, CPU update applied to the resulting state.
REQ-023 Snoop invalidating the target line while in INV_REQ before grant SHALL convert the request to WRITE_MISS (MISS_REQ, no write-back).
REQ-024 Snoop hitting the victim in WB before grant SHALL supply data via snoop_wb and the controller SHALL drop WB and go MISS_REQ.

Reset
REQ-025 reset_n low SHALL immediately set all lines I, tags and data 0, FSM IDLE, all outputs 0 except cpu_req_ready=1.
REQ-026 Reset mid-transaction SHALL abandon it with no response; bus_req_valid deasserts asynchronously.

Configuration
REQ-027 With MSI_CACHE_STATS_EN defined, SHALL add outputs hit_count and miss_count (16 bits each, saturating at 0xFFFF, incremented at acceptance, cleared by reset); without it, these ports and counters SHALL not exist.

Structure
REQ-028 Package msi_cache_pkg SHALL hold line-state and bus-cmd encodings, FSM state encoding and index/tag width functions.
REQ-029 Storage SHALL be sub-module msi_cache_array: tag/state/data per line, one CPU read port, one snoop read port, one prioritised write port.

Verification (ADDR_W=3, DATA_W=4, NUM_BLOCKS=2)
REQ-030 Read 3'b010 cold -> READ_MISS 010, fill 4'hA -> resp rdata 4'hA, line0 S; repeat read -> resp next cycle, no bus activity.
REQ-031 Write 4'h5 to 010 with line0 S -> INVALIDATE 010, grant -> line0 M, resp; read 010 -> 4'h5.
REQ-032 Line0 M (tag 01, data 5), read 3'b100 -> WRITE_BACK 010 data 5, then READ_MISS 100, fill 4'h3 -> rdata 4'h3.
REQ-033 Line1 M data 4'h7, snoop READ_MISS 3'b011 -> snoop_wb_valid with 4'h7 next cycle, line1 S; snoop WRITE_MISS 011 -> line1 I.
REQ-034 Write hit in S held in INV_REQ (bus_req_ready=0), snoop INVALIDATE same address -> bus_req_cmd becomes WRITE_MISS; fill -> line M, resp.
REQ-035 reset_n low during FILL -> bus_req_valid 0 immediately, all lines I, no cpu_resp_valid.
